// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and result flag bundle.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_INC = 3'd2,
    OP_DEC = 3'd3,
    OP_ADC = 3'd4,
    OP_SBB = 3'd5,
    OP_AND = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic ovf;
    logic neg;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and carry/zero/ovf/neg flags from opcode, a, b, cin.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the wrapping pipeline decides when the result is used.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                cin,
  output logic [DATA_W-1:0]   result,
  output alu_flags_t          flags
);

  logic            op_defined;
  alu_op_e         op;
  logic [DATA_W:0] wide;
  logic [DATA_W-1:0] rhs;
  logic            is_sub;
  logic            is_arith;

  // Codes above 7 only exist when the opcode field is wider than 3 bits.
  generate
    if (OPCODE_W > 3) begin : g_wide_op
      assign op_defined = ~|opcode[OPCODE_W-1:3];
    end else begin : g_narrow_op
      assign op_defined = 1'b1;
    end
  endgenerate

  assign op = alu_op_e'(opcode[2:0]);

  // One extra bit holds the carry (or borrow for subtracts); rhs is the
  // second operand as seen by the signed-overflow test.
  always_comb begin
    wide     = '0;
    rhs      = '0;
    is_sub   = 1'b0;
    is_arith = 1'b0;
    case (op)
      OP_ADD: begin
        rhs      = b;
        wide     = {1'b0, a} + {1'b0, rhs};
        is_arith = 1'b1;
      end
      OP_SUB: begin
        rhs      = b;
        wide     = {1'b0, a} - {1'b0, rhs};
        is_sub   = 1'b1;
        is_arith = 1'b1;
      end
      OP_INC: begin
        rhs      = DATA_W'(1);
        wide     = {1'b0, a} + {1'b0, rhs};
        is_arith = 1'b1;
      end
      OP_DEC: begin
        rhs      = DATA_W'(1);
        wide     = {1'b0, a} - {1'b0, rhs};
        is_sub   = 1'b1;
        is_arith = 1'b1;
      end
      OP_ADC: begin
        rhs      = b;
        wide     = {1'b0, a} + {1'b0, rhs} + (DATA_W+1)'(cin);
        is_arith = 1'b1;
      end
      OP_SBB: begin
        rhs      = b;
        wide     = {1'b0, a} - {1'b0, rhs} - (DATA_W+1)'(cin);
        is_sub   = 1'b1;
        is_arith = 1'b1;
      end
      OP_AND:  wide = {1'b0, a & b};
      OP_XOR:  wide = {1'b0, a ^ b};
      default: wide = '0;
    endcase
    if (!op_defined) begin
      wide     = '0;
      is_arith = 1'b0;
    end
    result      = wide[DATA_W-1:0];
    flags.carry = wide[DATA_W];
    flags.zero  = op_defined && (result == '0);
    flags.neg   = result[DATA_W-1];
    // Add overflows when like-signed operands give a differently-signed
    // result; subtract when unlike-signed operands do. cin never changes this.
    flags.ovf   = is_arith
                  && (is_sub ? (a[DATA_W-1] != rhs[DATA_W-1]) : (a[DATA_W-1] == rhs[DATA_W-1]))
                  && (result[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU (operand register, result register) with stored carry for ADC/SBB chains.
// Latency: 2 cycles from acceptance to out_valid; 1 beat/cycle while out_ready is high.
// Backpressure: full valid/ready; stage 1 holds its beat, in_ready drops only when both stages are full.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int OPCODE_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] in_opcode,
  input  logic [DATA_W-1:0]   in_op1,
  input  logic [DATA_W-1:0]   in_op2,
  input  logic                carry_clr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic                out_carry,
  output logic                out_zero,
  output logic                out_ovf,
  output logic                out_neg
);

  logic                s1_valid_q,  s1_valid_d;
  logic [OPCODE_W-1:0] s1_opcode_q, s1_opcode_d;
  logic [DATA_W-1:0]   s1_a_q,      s1_a_d;
  logic [DATA_W-1:0]   s1_b_q,      s1_b_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   result_q,    result_d;
  alu_flags_t          flags_q,     flags_d;
  logic                carry_q,     carry_d;

  logic                s2_adv;
  logic                in_fire;
  logic                s1_fire;
  logic                cin;
  logic                s1_arith;
  logic [DATA_W-1:0]   core_result;
  alu_flags_t          core_flags;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign s1_fire  = s1_valid_q && s2_adv;
  // carry_clr overrides the stored carry for the op advancing this cycle.
  assign cin      = carry_clr ? 1'b0 : carry_q;
  // Opcodes 0-5 produce a carry worth keeping; 6, 7 and undefined codes do not.
  assign s1_arith = (s1_opcode_q < OPCODE_W'(6));

  alu_core #(
    .DATA_W   (DATA_W),
    .OPCODE_W (OPCODE_W)
  ) u_core (
    .opcode (s1_opcode_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .cin    (cin),
    .result (core_result),
    .flags  (core_flags)
  );

  // Next-state for both pipeline stages and the stored carry.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_opcode_d = s1_opcode_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    carry_d     = carry_q;

    if (s1_fire) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_opcode_d = in_opcode;
      s1_a_d      = in_op1;
      s1_b_d      = in_op2;
    end

    if (s1_fire) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      flags_d     = core_flags;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (s1_fire && s1_arith) begin
      carry_d = core_flags.carry;
    end else if (carry_clr) begin
      carry_d = 1'b0;
    end
  end

  // State registers with synchronous reset; in-flight beats are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      carry_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opcode_q <= s1_opcode_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_carry  = flags_q.carry;
  assign out_zero   = flags_q.zero;
  assign out_ovf    = flags_q.ovf;
  assign out_neg    = flags_q.neg;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at DATA_W=8 plus a short DATA_W=256 smoke run.
// Latency: checks the 2-cycle acceptance-to-output timing on the first beat.
// Backpressure: stalls the consumer to check holding, in_ready and in-order delivery.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int WW = 256;
  localparam int OW = 3;

  typedef logic [WW+3:0] cv_t;
  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
    logic         n;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, carry_clr, out_valid, out_ready;
  logic [OW-1:0] in_opcode;
  logic [W-1:0]  in_op1, in_op2, out_result;
  logic          out_carry, out_zero, out_ovf, out_neg;

  logic          w_in_valid, w_in_ready, w_carry_clr, w_out_valid, w_out_ready;
  logic [OW-1:0] w_in_opcode;
  logic [WW-1:0] w_in_op1, w_in_op2, w_out_result;
  logic          w_out_carry, w_out_zero, w_out_ovf, w_out_neg;

  alu_pipe #(.DATA_W(W), .OPCODE_W(OW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_op1(in_op1), .in_op2(in_op2), .carry_clr(carry_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .out_ovf(out_ovf), .out_neg(out_neg)
  );

  alu_pipe #(.DATA_W(WW), .OPCODE_W(OW)) u_wide (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_opcode(w_in_opcode), .in_op1(w_in_op1), .in_op2(w_in_op2), .carry_clr(w_carry_clr),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_result(w_out_result),
    .out_carry(w_out_carry), .out_zero(w_out_zero), .out_ovf(w_out_ovf), .out_neg(w_out_neg)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;

  task automatic check(input string name, input cv_t act, input cv_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic ec, input logic ez,
                              input logic ev, input logic en);
    mk = '{res: r, c: ec, z: ez, v: ev, n: en};
  endfunction

  // Monitor: every beat the consumer takes is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got result %0h with no beat pending", out_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("beat", cv_t'({out_result, out_carry, out_zero, out_ovf, out_neg}), cv_t'(e));
      end
    end
  end

  // Present one beat and return #1 after the edge that accepted it (in_valid left high).
  task automatic send(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input exp_t e);
    bit acc;
    acc       = 1'b0;
    in_valid  = 1'b1;
    in_opcode = op;
    in_op1    = a;
    in_op2    = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready 0 for 50 cycles want 1 (op %0d)", op);
    end else begin
      sb.push_back(e);
      n_acc++;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", cv_t'(sb.size()), cv_t'(0));
  endtask

  task automatic wide_beat(input logic [OW-1:0] op, input logic [WW-1:0] a,
                           input logic [WW-1:0] b, input logic [WW-1:0] er,
                           input logic [3:0] ef);
    w_in_valid  = 1'b1;
    w_in_opcode = op;
    w_in_op1    = a;
    w_in_op2    = b;
    @(posedge clk);
    #1;
    w_in_valid  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (w_out_valid) break;
    end
    check("wide_beat", cv_t'({w_out_valid, w_out_result, w_out_carry, w_out_zero, w_out_ovf, w_out_neg}),
          cv_t'({1'b1, er, ef}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w_ones, w_msb;
    w_ones = '1;
    w_msb  = {1'b1, {(WW-1){1'b0}}};

    rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_op1 = '0; in_op2 = '0;
    carry_clr = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_opcode = '0; w_in_op1 = '0; w_in_op2 = '0;
    w_carry_clr = 1'b0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", cv_t'(in_ready), cv_t'(1));
    check("rst_outputs", cv_t'({out_valid, out_result, out_carry, out_zero, out_ovf, out_neg}), cv_t'(0));
    check("rst_carry_q", cv_t'(u_dut.carry_q), cv_t'(0));
    @(posedge clk);
    #1;

    // First beat and its latency: nothing in the cycle after acceptance, valid the one after.
    send(OP_ADD, 8'hF0, 8'h20, mk(8'h10, 1, 0, 0, 0));
    idle();
    @(negedge clk);
    check("lat_cycle1", cv_t'(out_valid), cv_t'(0));
    @(negedge clk);
    check("lat_cycle2", cv_t'(out_valid), cv_t'(1));
    @(posedge clk);
    #1;
    drain();

    // Back-to-back arithmetic and wrap-around; SBB picks up the borrow from DEC.
    send(OP_SUB, 8'h00, 8'h01, mk(8'hFF, 1, 0, 0, 1));
    send(OP_INC, 8'hFF, 8'h00, mk(8'h00, 1, 1, 0, 0));
    send(OP_ADD, 8'h7F, 8'h01, mk(8'h80, 0, 0, 1, 1));
    send(OP_DEC, 8'h00, 8'h00, mk(8'hFF, 1, 0, 0, 1));
    send(OP_SBB, 8'h10, 8'h05, mk(8'h0A, 0, 0, 0, 0));
    idle();
    drain();

    // 16-bit 0x00FF + 0x0001 as ADD low word then ADC high word -> 0x0100.
    carry_clr = 1'b1;
    send(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0));
    send(OP_ADC, 8'h00, 8'h00, mk(8'h01, 0, 0, 0, 0));
    carry_clr = 1'b0;
    idle();
    drain();

    // AND/XOR between the carry producer and ADC leave the stored carry alone.
    send(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0));
    send(OP_AND, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0));
    send(OP_XOR, 8'hAA, 8'hAA, mk(8'h00, 0, 1, 0, 0));
    send(OP_ADC, 8'h00, 8'h00, mk(8'h01, 0, 0, 0, 0));
    idle();
    drain();
    check("chain_carry_q", cv_t'(u_dut.carry_q), cv_t'(0));

    // carry_clr in the same cycle an ADC advances: cin is 0, op's carry is stored.
    send(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0));
    send(OP_ADC, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0));
    idle();
    carry_clr = 1'b1;
    @(posedge clk);
    #1 carry_clr = 1'b0;
    drain();
    check("clr_collision_carry_q", cv_t'(u_dut.carry_q), cv_t'(0));

    // carry_clr alone clears a set carry.
    send(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0));
    idle();
    drain();
    check("carry_set", cv_t'(u_dut.carry_q), cv_t'(1));
    carry_clr = 1'b1;
    @(posedge clk);
    #1 carry_clr = 1'b0;
    check("clr_alone_carry_q", cv_t'(u_dut.carry_q), cv_t'(0));
    send(OP_ADC, 8'h00, 8'h00, mk(8'h00, 0, 1, 0, 0));
    idle();
    drain();

    // Backpressure: two beats fill the pipe, outputs hold, then all four drain in order.
    out_ready = 1'b0;
    n_acc     = 0;
    fork
      begin
        send(OP_XOR, 8'h01, 8'h02, mk(8'h03, 0, 0, 0, 0));
        send(OP_AND, 8'h0F, 8'hFF, mk(8'h0F, 0, 0, 0, 0));
        send(OP_ADD, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0));
        send(OP_SUB, 8'h05, 8'h03, mk(8'h02, 0, 0, 0, 0));
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", cv_t'(in_ready), cv_t'(0));
        check("bp_accepted", cv_t'(n_acc), cv_t'(2));
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_hold", cv_t'({out_valid, out_result, out_carry, out_zero, out_ovf, out_neg}),
                cv_t'({1'b1, 8'h03, 4'b0000}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full: nothing survives, carry is cleared.
    out_ready = 1'b0;
    send(OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0));
    send(OP_ADD, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0));
    idle();
    check("pre_rst_carry_q", cv_t'(u_dut.carry_q), cv_t'(1));
    check("pre_rst_full", cv_t'(in_ready), cv_t'(0));
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", cv_t'({out_valid, out_result, out_carry, out_zero, out_ovf, out_neg}), cv_t'(0));
    check("mid_rst_in_ready", cv_t'(in_ready), cv_t'(1));
    check("mid_rst_carry_q", cv_t'(u_dut.carry_q), cv_t'(0));
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(OP_ADC, 8'h00, 8'h00, mk(8'h00, 0, 1, 0, 0));
    idle();
    drain();

    // DATA_W=256 smoke: full-width carry-out and signed overflow at the top bit.
    wide_beat(OP_ADD, w_ones, WW'(1), '0, 4'b1100);
    wide_beat(OP_INC, ~w_msb, '0, w_msb, 4'b0011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-register ALU.
- Adds a valid/ready handshake with full backpressure.
- Adds a stored carry flag so ADC/SBB can chain multi-word arithmetic across successive transactions, plus overflow and negative flags.
- Sits between an operand-issuing controller and a result consumer in the datapath.

Parameters:
- DATA_W, 256, operand/result width in bits (>=2).
- OPCODE_W, 3, opcode width; only codes 0..7 are defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_opcode  in  OPCODE_W  operation select.
- in_op1  in  DATA_W  operand A.
- in_op2  in  DATA_W  operand B.
- carry_clr  in  1  clear the stored carry (start of a new multi-word chain).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  result.
- out_carry  out  1  carry/borrow of this result.
- out_zero  out  1  out_result == 0.
- out_ovf  out  1  signed overflow.
- out_neg  out  1  out_result[DATA_W-1].

Behaviour:
- Reset (rst high at a rising edge):
  - s1_valid, out_valid, out_result, out_carry, out_zero, out_ovf, out_neg and carry_q all go to 0.
  - In-flight beats are discarded. in_ready is 1 in the first cycle after reset.
- Stage 1, operand register:
  - Capture opcode/op1/op2 on in_valid && in_ready.
  - in_ready = !s1_valid || s2_adv, where s2_adv = !out_valid || out_ready.
- Stage 2, result register:
  - When s1_valid && s2_adv: compute from the stage-1 registers, register the result and flags, and set out_valid = 1.
  - When out_valid && out_ready and no new beat advances: out_valid goes to 0.
- Latency: 2 cycles from input acceptance to out_valid with no stall. Throughput is 1 beat/cycle while out_ready = 1.
- Hold rules:
  - While out_valid && !out_ready, all out_* signals are stable.
  - The stage-1 beat is held. in_ready drops only when both stages are full.
- Effective carry-in: cin = carry_clr ? 0 : carry_q, sampled in the cycle the op advances to stage 2.
- Arithmetic is evaluated in DATA_W+1 bits; carry = bit DATA_W (borrow for subtract ops).
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 INC: a+1.
  - 3 DEC: a-1.
  - 4 ADC: a+b+cin.
  - 5 SBB: a-b-cin.
  - 6 AND: a&b, carry=0.
  - 7 XOR: a^b, carry=0.
- Flags:
  - zero: the DATA_W-bit result is 0.
  - neg: MSB of the result.
  - ovf: two's-complement overflow for opcodes 0-5; 0 for 6-7.
- Stored carry carry_q:
  - Updated with the computed carry when opcodes 0-5 advance to stage 2.
  - Unchanged by 6-7.
  - If carry_clr is high and no arithmetic op advances, carry_q <= 0.
  - If an arithmetic op advances in the same cycle, the op's carry is stored (it already used cin = 0).
- Chaining hazard: back-to-back ADC/SBB needs no stall, because the carry is consumed and produced in the same stage.
- Wrap-around:
  - INC of all-ones gives 0, carry=1, zero=1.
  - DEC of 0 gives all-ones, carry=1.
- Opcodes outside 0..7 (OPCODE_W > 3): result 0 and all flags 0; carry_q unchanged.
- Simultaneous in_valid and out_ready while both stages are full: the output drains, stage 1 advances and the input is accepted, all in one cycle.

Decomposition:
- Package alu_pkg holds:
  - typedef enum alu_op_e {OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC, OP_SBB, OP_AND, OP_XOR}.
  - struct alu_flags_t {carry, zero, ovf, neg}.
- One sub-module, alu_core: purely combinational. Inputs are opcode, a, b and cin; outputs are result and flags. alu_pipe wraps it with the two pipeline registers, the handshake and carry_q.

Test Plan (bench at DATA_W=8, plus one smoke run at DATA_W=256):
- Reset then ADD 0xF0+0x20, out_ready=1 -> out_valid 2 cycles after acceptance; result 0x10, carry=1, zero=0, ovf=0, neg=0.
- SUB 0x00-0x01 -> 0xFF, carry=1, neg=1. INC 0xFF -> 0x00, carry=1, zero=1. ADD 0x7F+0x01 -> 0x80, ovf=1.
- Chain with carry_clr=1 on the first beat: ADD 0xFF+0x01 (->0x00, carry=1), then ADC 0x00+0x00 in the next cycle -> 0x01, carry=0. A 16-bit 0x00FF+0x0001 gives 0x0100.
- Backpressure: stream 4 beats while holding out_ready=0 -> in_ready falls after 2 accepted beats and out_* stay stable. Releasing out_ready delivers all 4 beats in order with none dropped or duplicated.
- carry_clr collision: carry_q=1, ADC 0x01+0x01 advances with carry_clr=1 -> result 0x02 (cin=0) and carry_q=0 afterwards. carry_clr alone then leaves carry_q=0. AND/XOR between ADC beats leave carry_q unchanged.
- Reset mid-stream with both stages full -> next cycle out_valid=0, all outputs 0, carry_q=0, in_ready=1; no stale beat ever appears.
